// File: rtl/tx_sender.sv
// Drains the transmit byte buffer and serializes each byte as an 8N1 UART frame, LSB first.
// Bytes are fetched through the asynchronous read port in the single IDLE launch cycle.
module tx_sender #(
  parameter int CLK_PER_BIT = 868,
  parameter int DEPTH       = 50001,
  parameter int AW          = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] wptr,
  input  logic          hold,
  output logic [AW-1:0] ra,
  input  logic [7:0]    rd,
  output logic          txd,
  output logic          busy,
  output logic          empty
);

  localparam int TW = $clog2(CLK_PER_BIT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(CLK_PER_BIT - 1);
  localparam logic [AW-1:0] RA_LAST    = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [TW-1:0] timer_r, timer_s;
  logic [2:0]    bit_r, bit_s;
  logic [7:0]    shreg_r, shreg_s;
  logic [AW-1:0] ra_r, ra_s;
  logic          txd_r, txd_s;
  logic          busy_r, busy_s;
  logic          launch_s;
  logic          bit_end_s;

  assign launch_s  = (state_r == IDLE) && (ra_r != wptr) && !hold;
  assign bit_end_s = (timer_r == TIMER_LAST);

  // State and datapath registers, synchronous reset drops any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      timer_r <= '0;
      bit_r   <= 3'd0;
      shreg_r <= 8'h00;
      ra_r    <= '0;
      txd_r   <= 1'b1;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      timer_r <= timer_s;
      bit_r   <= bit_s;
      shreg_r <= shreg_s;
      ra_r    <= ra_s;
      txd_r   <= txd_s;
      busy_r  <= busy_s;
    end
  end

  // Next-state selection.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (launch_s) state_s = START; else state_s = IDLE;
      START:   if (bit_end_s) state_s = DATA; else state_s = START;
      DATA:    if (bit_end_s && (bit_r == 3'd7)) state_s = STOP; else state_s = DATA;
      STOP:    if (bit_end_s) state_s = IDLE; else state_s = STOP;
      default: state_s = IDLE;
    endcase
  end

  // Next values of the registered outputs, bit timer and shift register.
  always_comb begin
    timer_s = timer_r;
    bit_s   = bit_r;
    shreg_s = shreg_r;
    ra_s    = ra_r;
    txd_s   = txd_r;
    busy_s  = busy_r;
    case (state_r)
      IDLE: begin
        if (launch_s) begin
          shreg_s = rd;
          ra_s    = (ra_r == RA_LAST) ? {AW{1'b0}} : ra_r + AW'(1);
          txd_s   = 1'b0;
          busy_s  = 1'b1;
          timer_s = '0;
          bit_s   = 3'd0;
        end else begin
          txd_s = 1'b1;
        end
      end
      START, DATA, STOP: begin
        if (bit_end_s) begin
          timer_s = '0;
          case (state_r)
            START: begin
              txd_s = shreg_r[0];
              bit_s = 3'd0;
            end
            DATA: begin
              if (bit_r == 3'd7) begin
                txd_s = 1'b1;
              end else begin
                bit_s = bit_r + 3'd1;
                txd_s = shreg_r[bit_r + 3'd1];
              end
            end
            STOP: begin
              txd_s  = 1'b1;
              busy_s = 1'b0;
            end
            default: txd_s = 1'b1;
          endcase
        end else begin
          timer_s = timer_r + TW'(1);
        end
      end
      default: begin
        txd_s  = 1'b1;
        busy_s = 1'b0;
      end
    endcase
  end

  assign ra    = ra_r;
  assign txd   = txd_r;
  assign busy  = busy_r;
  assign empty = (ra_r == wptr);

endmodule
